// File: rtl/mcx_seq_core_if.sv
// Program-memory fetch handshake between mcx_seq_core (master) and the instruction store (slave).
interface mcx_seq_core_if #(
   parameter int unsigned PC_W  = 4,
   parameter int unsigned ARG_W = 12
) ();
   logic                  imem_req;
   logic [PC_W-1:0]       imem_addr;
   logic                  imem_valid;
   logic [6+3*ARG_W-1:0]  imem_line;

   modport master (output imem_req, output imem_addr, input imem_valid, input imem_line);
   modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_line);
endinterface

// File: rtl/mcx_seq_core.sv
// MCX fetch/execute sequencer: FETCH -> WAIT -> EXEC with terminal HALT, flags and register file.
// Optional one-entry CALL/RET return register enabled by defining MCX_CALL_EN.
module mcx_seq_core #(
   parameter int unsigned DATA_W  = 11,
   parameter int unsigned ARG_W   = 12,
   parameter int unsigned PC_W    = 4,
   parameter int unsigned LAST_PC = 6,
   parameter int unsigned NREG    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mcx_seq_core_if.master       imem,
   output logic [DATA_W-1:0]    acc_out,
   output logic [PC_W-1:0]      pc_out,
   output logic [1:0]           flags_out,
   output logic                 retire,
   output logic                 halted
);
   localparam int unsigned LINE_W = 6 + 3*ARG_W;
   localparam int unsigned IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [DATA_W-1:0]    regs_q [NREG];
   logic [DATA_W-1:0]    regs_d [NREG];
   logic [1:0]           flags_q, flags_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic                 req_q, req_d;
   logic                 retire_q, retire_d;
`ifdef MCX_CALL_EN
   logic [PC_W-1:0]      ra_q, ra_d;
`endif

   logic [1:0]           cond;
   logic [3:0]           op;
   logic [ARG_W-1:0]     a1, a2, a3;
   logic [IDX_W-1:0]     i1, i2, i3;
   logic [DATA_W-1:0]    opnd1, opnd2, imm, alu;
   logic                 alu_wr, cond_ok;
   logic [PC_W-1:0]      seq_pc, jmp_pc;

   assign cond  = line_q[LINE_W-1 -: 2];
   assign op    = line_q[LINE_W-3 -: 4];
   assign a1    = line_q[3*ARG_W-1 -: ARG_W];
   assign a2    = line_q[2*ARG_W-1 -: ARG_W];
   assign a3    = line_q[ARG_W-1:0];
   assign i1    = IDX_W'(a1 % ARG_W'(NREG));
   assign i2    = IDX_W'(a2 % ARG_W'(NREG));
   assign i3    = IDX_W'(a3 % ARG_W'(NREG));
   assign imm   = DATA_W'(a2);
   assign opnd1 = regs_q[i1];
   assign opnd2 = regs_q[i2];

   assign seq_pc = (pc_q == PC_W'(LAST_PC)) ? '0 : pc_q + PC_W'(1);
   assign jmp_pc = (a1 <= ARG_W'(LAST_PC)) ? PC_W'(a1) : '0;

   always_comb begin
      cond_ok = 1'b1;
      unique case (cond)
         2'b00: cond_ok = 1'b1;
         2'b01: cond_ok = flags_q[0];
         2'b10: cond_ok = flags_q[1];
         2'b11: cond_ok = ~flags_q[0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      regs_d   = regs_q;
      flags_d  = flags_q;
      line_d   = line_q;
      req_d    = req_q;
      retire_d = 1'b0;
      alu      = '0;
      alu_wr   = 1'b0;
`ifdef MCX_CALL_EN
      ra_d     = ra_q;
`endif
      unique case (state_q)
         S_FETCH: begin
            req_d   = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem.imem_valid) begin
               line_d  = imem.imem_line;
               req_d   = 1'b0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            retire_d = 1'b1;
            pc_d     = seq_pc;
            state_d  = S_FETCH;
            if (cond_ok) begin
               unique case (op)
                  4'h1: regs_d[i3] = imm;
                  4'h2: begin alu = opnd1 + opnd2; alu_wr = 1'b1; end
                  4'h3: pc_d = jmp_pc;
                  4'h4: begin alu = opnd1 - opnd2; alu_wr = 1'b1; end
                  4'h5: begin alu = opnd1 & opnd2; alu_wr = 1'b1; end
                  4'h6: begin alu = opnd1 | opnd2; alu_wr = 1'b1; end
                  4'h7: begin alu = opnd1 ^ opnd2; alu_wr = 1'b1; end
                  4'h8: regs_d[i3] = opnd1;
`ifdef MCX_CALL_EN
                  4'h9: begin ra_d = seq_pc; pc_d = jmp_pc; end
                  4'hA: pc_d = ra_q;
`else
                  4'h9, 4'hA: ;
`endif
                  4'hF: begin pc_d = pc_q; state_d = S_HALT; end
                  default: ;
               endcase
               // R0 is the accumulator, so ALU results land in regs_d[0]
               if (alu_wr) begin
                  regs_d[0] = alu;
                  flags_d   = {alu[DATA_W-1], alu == '0};
               end
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         flags_q  <= '0;
         line_q   <= '0;
         req_q    <= 1'b0;
         retire_q <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
`ifdef MCX_CALL_EN
         ra_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         flags_q  <= flags_d;
         line_q   <= line_d;
         req_q    <= req_d;
         retire_q <= retire_d;
         regs_q   <= regs_d;
`ifdef MCX_CALL_EN
         ra_q     <= ra_d;
`endif
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign acc_out        = regs_q[0];
   assign pc_out         = pc_q;
   assign flags_out      = flags_q;
   assign retire         = retire_q;
   assign halted         = (state_q == S_HALT);
endmodule

// File: tb/tb_mcx_seq_core.sv
// Scoreboard bench for mcx_seq_core: directed programs, expected retire state queued, monitor compares.
module tb_mcx_seq_core;
   localparam int unsigned DATA_W  = 11;
   localparam int unsigned ARG_W   = 12;
   localparam int unsigned PC_W    = 4;
   localparam int unsigned LAST_PC = 6;
   localparam int unsigned NREG    = 4;
   localparam int unsigned LINE_W  = 6 + 3*ARG_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [DATA_W-1:0] acc_out;
   logic [PC_W-1:0]   pc_out;
   logic [1:0]        flags_out;
   logic              retire, halted;

   mcx_seq_core_if #(.PC_W(PC_W), .ARG_W(ARG_W)) bus ();

   mcx_seq_core #(.DATA_W(DATA_W), .ARG_W(ARG_W), .PC_W(PC_W), .LAST_PC(LAST_PC), .NREG(NREG)) dut (
      .clk(clk), .rst(rst), .imem(bus),
      .acc_out(acc_out), .pc_out(pc_out), .flags_out(flags_out),
      .retire(retire), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] acc;
      logic [1:0]        flags;
      logic              hlt;
   } exp_t;

   exp_t exp_q[$];
   int vectors     = 0;
   int miscompares = 0;
   logic [LINE_W-1:0] mem [16];
   int mem_delay = 0;
   int late_req  = 0;

   function automatic logic [LINE_W-1:0] ins(input logic [1:0] c, input logic [3:0] op,
                                              input int a1, input int a2, input int a3);
      return {c, op, ARG_W'(a1), ARG_W'(a2), ARG_W'(a3)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ret(input int pc, input int acc, input int flags, input int hlt);
      exp_t e;
      e.pc = PC_W'(pc); e.acc = DATA_W'(acc); e.flags = 2'(flags); e.hlt = 1'(hlt);
      exp_q.push_back(e);
   endtask

   task automatic load_nops();
      for (int i = 0; i < 16; i++) mem[i] = ins(2'b00, 4'h0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d retires outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // instruction memory: answers mem_delay cycles after seeing req; late_req injects a stray valid
   initial begin
      int cnt;
      int late_seen;
      cnt = 0;
      late_seen = 0;
      bus.imem_valid = 1'b0;
      bus.imem_line  = '0;
      forever begin
         @(negedge clk);
         if (late_req != late_seen) begin
            late_seen      = late_req;
            bus.imem_valid = 1'b1;
            bus.imem_line  = ins(2'b00, 4'h1, 0, 77, 0);
         end else if (bus.imem_req) begin
            if (cnt >= mem_delay) begin
               bus.imem_valid = 1'b1;
               bus.imem_line  = mem[bus.imem_addr];
            end else begin
               bus.imem_valid = 1'b0;
            end
            cnt++;
         end else begin
            bus.imem_valid = 1'b0;
            cnt = 0;
         end
      end
   end

   // retire monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && retire) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_retire: pc=%0h acc=%0h, required no retire", pc_out, acc_out);
            end else begin
               e = exp_q.pop_front();
               check("retire_pc",     32'(pc_out),    32'(e.pc));
               check("retire_acc",    32'(acc_out),   32'(e.acc));
               check("retire_flags",  32'(flags_out), 32'(e.flags));
               check("retire_halted", 32'(halted),    32'(e.hlt));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      @(negedge clk);

      // reset values and first program: LDI/LDI/ADD/SUB, then Z-conditional JMP taken
      load_nops();
      mem[0] = ins(2'b00, 4'h1, 0, 5, 1);
      mem[1] = ins(2'b00, 4'h1, 0, 3, 2);
      mem[2] = ins(2'b00, 4'h2, 1, 2, 0);
      mem[3] = ins(2'b00, 4'h4, 1, 1, 0);
      mem[4] = ins(2'b01, 4'h3, 0, 0, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req",    32'(bus.imem_req), 32'd0);
      check("rst_pc",     32'(pc_out),       32'd0);
      check("rst_acc",    32'(acc_out),      32'd0);
      check("rst_flags",  32'(flags_out),    32'd0);
      check("rst_retire", 32'(retire),       32'd0);
      check("rst_halted", 32'(halted),       32'd0);
      expect_ret(1, 0, 0, 0);
      expect_ret(2, 0, 0, 0);
      expect_ret(3, 8, 0, 0);
      expect_ret(4, 0, 1, 0);
      expect_ret(0, 0, 1, 0);
      expect_ret(1, 0, 1, 0);
      rst = 1'b1;
      drain(100);

      // AND, index wrap, Z=0 squash, !Z jump, OR, LAST_PC wrap
      load_nops();
      mem[0] = ins(2'b00, 4'h1, 0, 12, 5);
      mem[1] = ins(2'b00, 4'h1, 0, 10, 2);
      mem[2] = ins(2'b00, 4'h5, 1, 2, 0);
      mem[3] = ins(2'b01, 4'h3, 0, 0, 0);
      mem[4] = ins(2'b11, 4'h3, 6, 0, 0);
      mem[6] = ins(2'b00, 4'h6, 1, 6, 0);
      do_reset();
      expect_ret(1, 0, 0, 0);
      expect_ret(2, 0, 0, 0);
      expect_ret(3, 8, 0, 0);
      expect_ret(4, 8, 0, 0);
      expect_ret(6, 8, 0, 0);
      expect_ret(0, 14, 0, 0);
      expect_ret(1, 14, 0, 0);
      drain(100);

      // straight-line NOPs wrap after LAST_PC
      load_nops();
      do_reset();
      for (int i = 1; i <= 6; i++) expect_ret(i, 0, 0, 0);
      expect_ret(0, 0, 0, 0);
      drain(100);

      // JMP to LAST_PC allowed, JMP beyond it goes to 0
      load_nops();
      mem[0] = ins(2'b00, 4'h3, 6, 0, 0);
      mem[6] = ins(2'b00, 4'h3, 9, 0, 0);
      do_reset();
      expect_ret(6, 0, 0, 0);
      expect_ret(0, 0, 0, 0);
      expect_ret(6, 0, 0, 0);
      drain(100);

      // delayed imem_valid: request and address held, no retire meanwhile
      load_nops();
      mem[0] = ins(2'b00, 4'h1, 0, 7, 3);
      mem[1] = ins(2'b00, 4'h8, 3, 0, 0);
      mem_delay = 4;
      do_reset();
      expect_ret(1, 0, 0, 0);
      expect_ret(2, 7, 0, 0);
      n = 0;
      while (!bus.imem_req && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 4; i++) begin
         check("wait_req",    32'(bus.imem_req),  32'd1);
         check("wait_addr",   32'(bus.imem_addr), 32'd0);
         check("wait_retire", 32'(retire),        32'd0);
         @(negedge clk);
      end
      drain(100);
      mem_delay = 0;

      // DATA_W wrap to negative, conditional-N MOV, XOR zero, immediate truncation, HALT
      load_nops();
      mem[0] = ins(2'b00, 4'h1, 0, 1023, 1);
      mem[1] = ins(2'b00, 4'h1, 0, 1, 2);
      mem[2] = ins(2'b00, 4'h2, 1, 2, 0);
      mem[3] = ins(2'b10, 4'h8, 2, 0, 0);
      mem[4] = ins(2'b00, 4'h7, 1, 1, 0);
      mem[5] = ins(2'b00, 4'h1, 0, 'hFFF, 0);
      mem[6] = ins(2'b00, 4'hF, 0, 0, 0);
      do_reset();
      expect_ret(1, 0, 0, 0);
      expect_ret(2, 0, 0, 0);
      expect_ret(3, 'h400, 2, 0);
      expect_ret(4, 1, 2, 0);
      expect_ret(5, 0, 1, 0);
      expect_ret(6, 'h7FF, 1, 0);
      expect_ret(6, 'h7FF, 1, 1);
      drain(100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("halt_req",    32'(bus.imem_req), 32'd0);
         check("halt_flag",   32'(halted),       32'd1);
         check("halt_pc",     32'(pc_out),       32'd6);
      end

      // reset while waiting for a fetch; the stray valid afterwards must be ignored
      load_nops();
      mem[0] = ins(2'b00, 4'h1, 0, 99, 0);
      do_reset();
      expect_ret(1, 99, 0, 0);
      drain(100);
      mem_delay = 5;
      n = 0;
      while (!bus.imem_req && n < 20) begin @(negedge clk); n++; end
      check("rw_addr", 32'(bus.imem_addr), 32'd1);
      rst = 1'b0;
      late_req++;
      @(negedge clk);
      check("rw_req",    32'(bus.imem_req), 32'd0);
      check("rw_pc",     32'(pc_out),       32'd0);
      check("rw_acc",    32'(acc_out),      32'd0);
      check("rw_retire", 32'(retire),       32'd0);
      mem_delay = 0;
      rst = 1'b1;
      expect_ret(1, 99, 0, 0);
      drain(100);

`ifdef MCX_CALL_EN
      load_nops();
      mem[0] = ins(2'b00, 4'h9, 4, 0, 0);
      mem[4] = ins(2'b00, 4'h1, 0, 33, 0);
      mem[5] = ins(2'b00, 4'hA, 0, 0, 0);
      do_reset();
      expect_ret(4, 0, 0, 0);
      expect_ret(5, 33, 0, 0);
      expect_ret(1, 33, 0, 0);
      expect_ret(2, 33, 0, 0);
      drain(100);
`else
      load_nops();
      mem[0] = ins(2'b00, 4'h9, 4, 0, 0);
      mem[1] = ins(2'b00, 4'hA, 0, 0, 0);
      do_reset();
      expect_ret(1, 0, 0, 0);
      expect_ret(2, 0, 0, 0);
      drain(100);
`endif

      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
